read_control_mc: RTL and testbench

Multi-channel ring-buffer read sequencer, parametrised successor of the single-mode read controller. Counts completed half-packages written into the shared circular sample memory. For each queued package it replays the same address window once per enabled channel, back-to-back, and drives the readout mux with the channel id. It also emits latency-aligned valid/id/last qualifiers, a package-done pulse, and a sticky queue-overflow flag, so the packer needs no timing knowledge of the memory.

---
 rtl/read_control_mc.sv | 198 +++++++++++++++++++
 tb/tb_read_control_mc.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_control_mc.sv
// Multi-channel ring-buffer read sequencer: replays each queued package's address
// window once per enabled channel and emits read-latency-aligned qualifiers.
module read_control_mc #(
    parameter int N_CH   = 16,
    parameter int CH_W   = 4,
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 10,
    parameter int Q_W    = 6,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              live_rising,
    input  logic              read_start,
    input  logic [LEN_W-1:0]  HALF_PACKAGE_LENGTH,
    input  logic [ADDR_W-1:0] MEMORY_DEPTH,
    input  logic [N_CH-1:0]   ch_mask,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    output logic [CH_W-1:0]   input_id,
    output logic              rvalid,
    output logic [CH_W-1:0]   rid,
    output logic              rlast,
    output logic              pkg_done,
    output logic [Q_W-1:0]    n_mem_queue,
    output logic              queue_overflow,
    output logic              busy
);

    localparam int SUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DONE} state_t;

    state_t            r_state, w_stateNext;
    logic [LEN_W-1:0]  r_len, w_lenNext;
    logic [LEN_W-1:0]  r_cnt, w_cntNext;
    logic [N_CH-1:0]   r_mask, w_maskNext;
    logic [ADDR_W-1:0] r_initAddr, w_initAddrNext;
    logic [ADDR_W-1:0] r_raddr, w_raddrNext;
    logic [CH_W-1:0]   r_inputId, w_inputIdNext;
    logic [Q_W-1:0]    r_queue, w_queueNext;
    logic              r_overflow, w_overflowNext;

    logic              w_ren, w_done, w_lastWord, w_rlastNow;
    logic [ADDR_W-1:0] w_raddrInc, w_initAdv;
    logic [SUM_W-1:0]  w_sum, w_depthExt;
    logic              w_loadFound, w_nextFound;
    logic [CH_W-1:0]   w_loadId, w_nextId;

    assign w_ren      = (r_state == S_READ);
    assign w_done     = (r_state == S_DONE);
    assign w_lastWord = (r_cnt == r_len - LEN_W'(1));
    assign w_rlastNow = w_ren && w_lastWord;
    assign w_raddrInc = (r_raddr == MEMORY_DEPTH - ADDR_W'(1)) ? '0 : r_raddr + ADDR_W'(1);
    assign w_depthExt = {1'b0, MEMORY_DEPTH};
    assign w_sum      = {1'b0, r_initAddr} + SUM_W'(r_len);
    assign w_initAdv  = (w_sum >= w_depthExt) ? ADDR_W'(w_sum - w_depthExt) : ADDR_W'(w_sum);

    // Descending scans leave the lowest qualifying channel in the result.
    always_comb begin
        w_loadFound = 1'b0;
        w_loadId    = '0;
        w_nextFound = 1'b0;
        w_nextId    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_loadFound = 1'b1;
                w_loadId    = CH_W'(i);
            end
            if (r_mask[i] && (i > int'(r_inputId))) begin
                w_nextFound = 1'b1;
                w_nextId    = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_lenNext      = r_len;
        w_cntNext      = r_cnt;
        w_maskNext     = r_mask;
        w_initAddrNext = r_initAddr;
        w_raddrNext    = r_raddr;
        w_inputIdNext  = r_inputId;
        case (r_state)
            S_IDLE: begin
                if (r_queue != '0) w_stateNext = S_LOAD;
            end
            S_LOAD: begin
                w_lenNext  = HALF_PACKAGE_LENGTH;
                w_maskNext = ch_mask;
                if ((HALF_PACKAGE_LENGTH == '0) || !w_loadFound) begin
                    w_stateNext = S_DONE;
                end else begin
                    w_inputIdNext = w_loadId;
                    w_raddrNext   = r_initAddr;
                    w_cntNext     = '0;
                    w_stateNext   = S_READ;
                end
            end
            S_READ: begin
                if (!w_lastWord) begin
                    w_cntNext   = r_cnt + LEN_W'(1);
                    w_raddrNext = w_raddrInc;
                end else if (w_nextFound) begin
                    w_inputIdNext = w_nextId;
                    w_raddrNext   = r_initAddr;
                    w_cntNext     = '0;
                end else begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_initAddrNext = w_initAdv;
                // A start landing in DONE cancels the decrement, so the queue stays non-empty.
                if (read_start || (r_queue > Q_W'(1))) w_stateNext = S_LOAD;
                else                                  w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_queueNext    = r_queue;
        w_overflowNext = r_overflow;
        if (read_start && !w_done) begin
            if (&r_queue) w_overflowNext = 1'b1;
            else          w_queueNext    = r_queue + Q_W'(1);
        end else if (w_done && !read_start) begin
            w_queueNext = r_queue - Q_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (live_rising) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_initAddr <= '0;
            r_raddr    <= '0;
            r_inputId  <= '0;
            r_queue    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_len      <= w_lenNext;
            r_cnt      <= w_cntNext;
            r_mask     <= w_maskNext;
            r_initAddr <= w_initAddrNext;
            r_raddr    <= w_raddrNext;
            r_inputId  <= w_inputIdNext;
            r_queue    <= w_queueNext;
            r_overflow <= w_overflowNext;
        end
    end

    assign ren            = w_ren;
    assign raddr          = r_raddr;
    assign input_id       = r_inputId;
    assign pkg_done       = w_done;
    assign n_mem_queue    = r_queue;
    assign queue_overflow = r_overflow;
    assign busy           = (r_state != S_IDLE);

    generate
        if (RD_LAT == 0) begin : g_noDelay
            assign rvalid = w_ren;
            assign rid    = r_inputId;
            assign rlast  = w_rlastNow;
        end else begin : g_delay
            logic [RD_LAT-1:0] r_validPipe;
            logic [RD_LAT-1:0] r_lastPipe;
            logic [CH_W-1:0]   r_idPipe [RD_LAT];

            always_ff @(posedge clk) begin
                if (live_rising) begin
                    r_validPipe <= '0;
                    r_lastPipe  <= '0;
                    for (int i = 0; i < RD_LAT; i++) r_idPipe[i] <= '0;
                end else begin
                    r_validPipe[0] <= w_ren;
                    r_lastPipe[0]  <= w_rlastNow;
                    r_idPipe[0]    <= r_inputId;
                    for (int i = 1; i < RD_LAT; i++) begin
                        r_validPipe[i] <= r_validPipe[i-1];
                        r_lastPipe[i]  <= r_lastPipe[i-1];
                        r_idPipe[i]    <= r_idPipe[i-1];
                    end
                end
            end

            assign rvalid = r_validPipe[RD_LAT-1];
            assign rid    = r_idPipe[RD_LAT-1];
            assign rlast  = r_lastPipe[RD_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_read_control_mc.sv
// Bench for read_control_mc: package-level reference model checked every cycle,
// a table of directed package scenarios, hand-written corner sequences and random traffic.
module tb_read_control_mc;

    localparam int N_CH   = 16;
    localparam int CH_W   = 4;
    localparam int ADDR_W = 15;
    localparam int LEN_W  = 10;
    localparam int Q_W    = 6;
    localparam int RD_LAT = 2;
    localparam int QMAX   = (1 << Q_W) - 1;

    logic              clk = 1'b0;
    logic              live_rising = 1'b1;
    logic              read_start = 1'b0;
    logic [LEN_W-1:0]  HALF_PACKAGE_LENGTH = '0;
    logic [ADDR_W-1:0] MEMORY_DEPTH = 15'd32767;
    logic [N_CH-1:0]   ch_mask = '0;
    logic              ren, rvalid, rlast, pkg_done, queue_overflow, busy;
    logic [ADDR_W-1:0] raddr;
    logic [CH_W-1:0]   input_id, rid;
    logic [Q_W-1:0]    n_mem_queue;

    read_control_mc #(
        .N_CH(N_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .Q_W(Q_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .live_rising(live_rising), .read_start(read_start),
        .HALF_PACKAGE_LENGTH(HALF_PACKAGE_LENGTH), .MEMORY_DEPTH(MEMORY_DEPTH), .ch_mask(ch_mask),
        .ren(ren), .raddr(raddr), .input_id(input_id), .rvalid(rvalid), .rid(rid), .rlast(rlast),
        .pkg_done(pkg_done), .n_mem_queue(n_mem_queue), .queue_overflow(queue_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ren;
        int addr;
        int id;
        bit last;
        bit done;
    } planRec_t;

    typedef struct {
        int depth;
        int len;
        int mask;
        int nPkgs;
        int expRen;
        int expDone;
        int expLast;
    } vec_t;

    int nVectors = 0;
    int nFail    = 0;
    bit checkEn  = 1'b0;
    int cntRen, cntDone, cntLast;

    // Reference model: a pending-package count plus the list of cycles still to come for the current package.
    int       mq = 0;
    bit       movf = 1'b0;
    int       mInit = 0;
    int       mLen = 0;
    bit       mInLoad = 1'b0;
    planRec_t mPlan[$];
    bit       hRen[RD_LAT];
    int       hId[RD_LAT];
    bit       hLast[RD_LAT];

    function automatic planRec_t expNow();
        planRec_t r = '{0, 0, 0, 0, 0};
        if (!mInLoad && mPlan.size() > 0) r = mPlan[0];
        return r;
    endfunction

    function automatic bit expBusy();
        return mInLoad || (mPlan.size() > 0);
    endfunction

    always @(posedge clk) begin
        planRec_t cur;
        int       qPre;
        bit       wasDone, wasIdle;
        if (live_rising) begin
            mq = 0; movf = 0; mInit = 0; mLen = 0; mInLoad = 0;
            mPlan.delete();
            for (int i = 0; i < RD_LAT; i++) begin hRen[i] = 0; hId[i] = 0; hLast[i] = 0; end
        end else begin
            cur     = expNow();
            qPre    = mq;
            wasIdle = !expBusy();
            wasDone = !mInLoad && cur.done;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                hRen[i] = hRen[i-1]; hId[i] = hId[i-1]; hLast[i] = hLast[i-1];
            end
            hRen[0] = cur.ren; hId[0] = cur.id; hLast[0] = cur.last;
            if (read_start && !wasDone) begin
                if (mq == QMAX) movf = 1;
                else            mq++;
            end else if (wasDone && !read_start) begin
                mq--;
            end
            if (mInLoad) begin
                mInLoad = 0;
                mLen    = int'(HALF_PACKAGE_LENGTH);
                for (int ch = 0; ch < N_CH; ch++)
                    if (ch_mask[ch])
                        for (int w = 0; w < mLen; w++)
                            mPlan.push_back('{1, (mInit + w) % int'(MEMORY_DEPTH), ch, (w == mLen - 1), 0});
                mPlan.push_back('{0, 0, 0, 0, 1});
            end else if (mPlan.size() > 0) begin
                void'(mPlan.pop_front());
                if (wasDone) begin
                    mInit = (mInit + mLen) % int'(MEMORY_DEPTH);
                    if (mq > 0) mInLoad = 1;
                end
            end else if (wasIdle && qPre > 0) begin
                mInLoad = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        planRec_t e;
        if (checkEn) begin
            e = expNow();
            checkOutput("ren", 64'(ren), 64'(e.ren));
            checkOutput("pkg_done", 64'(pkg_done), 64'(e.done));
            checkOutput("busy", 64'(busy), 64'(expBusy()));
            checkOutput("n_mem_queue", 64'(n_mem_queue), 64'(mq));
            checkOutput("queue_overflow", 64'(queue_overflow), 64'(movf));
            checkOutput("rvalid", 64'(rvalid), 64'(hRen[RD_LAT-1]));
            checkOutput("rlast", 64'(rlast), 64'(hLast[RD_LAT-1]));
            if (e.ren) begin
                checkOutput("raddr", 64'(raddr), 64'(e.addr));
                checkOutput("input_id", 64'(input_id), 64'(e.id));
            end
            if (hRen[RD_LAT-1]) checkOutput("rid", 64'(rid), 64'(hId[RD_LAT-1]));
        end
    end

    task automatic applyStimulus(input logic start);
        @(negedge clk);
        if (ren)      cntRen++;
        if (pkg_done) cntDone++;
        if (rlast)    cntLast++;
        read_start = start;
    endtask

    task automatic doReset();
        @(negedge clk);
        live_rising = 1'b1;
        read_start  = 1'b0;
        @(negedge clk);
        live_rising = 1'b0;
        checkEn     = 1'b1;
        cntRen = 0; cntDone = 0; cntLast = 0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        do begin
            applyStimulus(1'b0);
            n++;
        end while ((busy || n_mem_queue != '0) && n < maxCycles);
        if (busy || n_mem_queue != '0) checkOutput("drainTimeout", 64'(busy), 64'(0));
        repeat (RD_LAT + 2) applyStimulus(1'b0);
    endtask

    task automatic waitFirstRen(input string name, input int expAddr, input int expId);
        bit found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0);
            if (ren) begin found = 1'b1; break; end
        end
        checkOutput({name, "Seen"}, 64'(found), 64'(1));
        if (found) begin
            checkOutput({name, "Addr"}, 64'(raddr), 64'(expAddr));
            checkOutput({name, "Id"}, 64'(input_id), 64'(expId));
        end
    endtask

    function automatic void newParams(input int depth);
        int lmax = (depth < 6) ? depth : 6;
        HALF_PACKAGE_LENGTH = LEN_W'($urandom_range(0, lmax));
        case ($urandom_range(0, 3))
            0:       ch_mask = N_CH'($urandom & $urandom & $urandom);
            1:       ch_mask = N_CH'(1 << $urandom_range(0, N_CH - 1));
            default: ch_mask = N_CH'($urandom);
        endcase
    endfunction

    initial begin
        #900_000;
        $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[7];
        bit   hit;
        int   depth;

        vecs[0] = '{32768 - 1, 4, 'hFFFF, 1, 64, 1, 16};
        vecs[1] = '{10, 4, 'hFFFF, 3, 192, 3, 48};
        vecs[2] = '{100, 3, 'h8005, 1, 9, 1, 3};
        vecs[3] = '{50, 5, 'h0000, 2, 0, 2, 0};
        vecs[4] = '{50, 0, 'h00FF, 1, 0, 1, 0};
        vecs[5] = '{7, 7, 'h0003, 2, 28, 2, 4};
        vecs[6] = '{3, 2, 'h8000, 3, 6, 3, 3};

        doReset();
        checkOutput("resetRen", 64'(ren), 64'(0));
        checkOutput("resetQueue", 64'(n_mem_queue), 64'(0));
        checkOutput("resetBusy", 64'(busy), 64'(0));
        checkOutput("resetRvalid", 64'(rvalid), 64'(0));

        foreach (vecs[v]) begin
            MEMORY_DEPTH        = ADDR_W'(vecs[v].depth);
            HALF_PACKAGE_LENGTH = LEN_W'(vecs[v].len);
            ch_mask             = N_CH'(vecs[v].mask);
            doReset();
            for (int p = 0; p < vecs[v].nPkgs; p++) begin
                applyStimulus(1'b1);
                applyStimulus(1'b0);
            end
            waitDrain(5000);
            checkOutput($sformatf("vec%0d_renCycles", v), 64'(cntRen), 64'(vecs[v].expRen));
            checkOutput($sformatf("vec%0d_pkgDone", v), 64'(cntDone), 64'(vecs[v].expDone));
            checkOutput($sformatf("vec%0d_rlast", v), 64'(cntLast), 64'(vecs[v].expLast));
        end

        // Start arriving in the DONE cycle with one package pending.
        MEMORY_DEPTH = 15'd100; HALF_PACKAGE_LENGTH = 10'd2; ch_mask = 16'h0001;
        doReset();
        applyStimulus(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0);
            if (pkg_done) begin hit = 1'b1; break; end
        end
        checkOutput("simulDoneSeen", 64'(hit), 64'(1));
        read_start = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        checkOutput("simulQueue", 64'(n_mem_queue), 64'(1));
        checkOutput("simulLoadBusy", 64'(busy), 64'(1));
        checkOutput("simulLoadRen", 64'(ren), 64'(0));
        waitFirstRen("simulNext", 2, 0);
        waitDrain(200);

        // Saturate the queue while a long package is in progress.
        MEMORY_DEPTH = 15'd32767; HALF_PACKAGE_LENGTH = 10'd20; ch_mask = 16'hFFFF;
        doReset();
        repeat (QMAX) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("satQueue", 64'(n_mem_queue), 64'(QMAX));
        checkOutput("satNoOverflow", 64'(queue_overflow), 64'(0));
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("ovfQueue", 64'(n_mem_queue), 64'(QMAX));
        checkOutput("ovfFlag", 64'(queue_overflow), 64'(1));
        repeat (20) applyStimulus(1'b0);
        checkOutput("ovfSticky", 64'(queue_overflow), 64'(1));
        doReset();
        checkOutput("ovfCleared", 64'(queue_overflow), 64'(0));

        // Reset while channel 5 is being read.
        MEMORY_DEPTH = 15'd1000; HALF_PACKAGE_LENGTH = 10'd3; ch_mask = 16'hFFFF;
        doReset();
        applyStimulus(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0);
            if (ren && input_id == 4'd5) begin hit = 1'b1; break; end
        end
        checkOutput("abortId5Seen", 64'(hit), 64'(1));
        live_rising = 1'b1;
        @(negedge clk);
        live_rising = 1'b0;
        checkOutput("abortRen", 64'(ren), 64'(0));
        checkOutput("abortQueue", 64'(n_mem_queue), 64'(0));
        checkOutput("abortRvalid", 64'(rvalid), 64'(0));
        checkOutput("abortBusy", 64'(busy), 64'(0));
        cntDone = 0;
        repeat (10) applyStimulus(1'b0);
        checkOutput("abortNoPkgDone", 64'(cntDone), 64'(0));
        applyStimulus(1'b1);
        waitFirstRen("abortRestart", 0, 0);
        waitDrain(200);

        // An empty-mask package still advances the window start.
        MEMORY_DEPTH = 15'd50; HALF_PACKAGE_LENGTH = 10'd5; ch_mask = 16'h0000;
        doReset();
        applyStimulus(1'b1);
        waitDrain(100);
        checkOutput("mask0Done", 64'(cntDone), 64'(1));
        checkOutput("mask0NoRen", 64'(cntRen), 64'(0));
        ch_mask = 16'h0010;
        applyStimulus(1'b1);
        waitFirstRen("mask0Next", 5, 4);
        waitDrain(100);

        // Random traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            depth = (seg % 2 == 1) ? int'($urandom_range(1, 12)) : int'($urandom_range(13, 32767));
            MEMORY_DEPTH = ADDR_W'(depth);
            newParams(depth);
            doReset();
            for (int c = 0; c < 800; c++) begin
                if ($urandom_range(0, 29) == 0) newParams(depth);
                applyStimulus($urandom_range(0, 24) == 0);
            end
            waitDrain(20000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule
